ad7606_ctrl: RTL
================

Name: ad7606_ctrl

Overview:
FPGA-side controller for the AD7606 8-channel simultaneous-sampling ADC parallel interface. It issues the ADC reset pulse and CONVST, tracks BUSY, and reads all channels with CS/RD strobes. Each channel is checked against FRSTDATA, and samples are delivered on a valid/ready stream to the capture FIFO. It sits between the acquisition sequencer (start_i) and the ADC pins.

Parameters:
NCH, 8, channels read per conversion (1..8)
T_RST, 4, adc_reset_o high width in clk cycles after reset_r release
T_CONV, 3, adc_convst_o low width in cycles
T_RDL, 3, adc_rd_o low width in cycles
T_RDH, 2, minimum adc_rd_o high width between reads
BUSY_TO, 1000, cycles allowed for the BUSY rise-plus-fall window before timeout

Ports:
clk  in  1  system clock
reset_r  in  1  reset, asynchronous, active-high
start_i  in  1  single-cycle conversion request
adc_reset_o  out  1  ADC RESET pin
adc_convst_o  out  1  CONVST A/B tied, active-low pulse
adc_cs_o  out  1  chip select, active-low
adc_rd_o  out  1  read strobe, active-low
adc_busy_i  in  1  ADC BUSY, asynchronous to clk
adc_frstdata_i  in  1  ADC FRSTDATA, asynchronous to clk
adc_db_i  in  16  ADC data bus, two's complement
sample_o  out  16  captured sample
chan_o  out  3  channel index of sample_o
valid_o  out  1  sample_o/chan_o valid
ready_i  in  1  downstream accept
busy_o  out  1  controller not IDLE
err_frst_o  out  1  sticky FRSTDATA mismatch, cleared by next accepted start_i
err_to_o  out  1  one-cycle pulse on BUSY timeout

Behaviour:
- Reset values: adc_reset_o=1, adc_convst_o=1, adc_cs_o=1, adc_rd_o=1, valid_o=0, sample_o=0, chan_o=0, busy_o=1, err_frst_o=0, err_to_o=0. All outputs are registered.
- adc_busy_i and adc_frstdata_i pass through a 2-flop synchronizer, giving 2-cycle latency. adc_db_i is sampled directly; it is stable by the end of RD low.
- States:
  - RST_ADC: hold adc_reset_o=1 for T_RST cycles, then go to IDLE.
  - IDLE: busy_o=0. On start_i, go to CONV.
  - CONV: adc_convst_o=0 for T_CONV cycles, then go to WAIT_HI.
  - WAIT_HI: wait for synced BUSY=1, then go to WAIT_LO.
  - WAIT_LO: wait for synced BUSY=0. Then assert adc_cs_o=0, set ch=0, go to RD_LO.
  - RD_LO: adc_rd_o=0 for T_RDL cycles. On the last cycle, latch adc_db_i into sample_o and ch into chan_o. Check FRSTDATA: it must be 1 when ch=0 and 0 otherwise; on mismatch set err_frst_o. Then go to RD_HI.
  - RD_HI: adc_rd_o=1 and valid_o=1 until ready_i. Leave RD_HI only when the sample has been accepted AND at least T_RDH cycles have elapsed. If ch=NCH-1, deassert adc_cs_o and go to IDLE; otherwise ch++ and go to RD_LO.
- The FRSTDATA check uses the synced value at the last RD_LO cycle. Its 2-cycle latency is covered by the constraint T_RDL>=3.
- Timeout: a single counter spans WAIT_HI+WAIT_LO. Reaching BUSY_TO cycles pulses err_to_o for one cycle and returns to IDLE with no samples emitted. The ADC is not reset.
- start_i outside IDLE is ignored. start_i in the same cycle that RD_HI returns to IDLE is also ignored.
- Backpressure: the ADC is held with CS low and RD high indefinitely. No samples are dropped. valid_o, sample_o and chan_o are stable while valid_o=1 and ready_i=0.
- valid_o drops the cycle after the handshake completes, unless the next sample is already latched. It cannot be, because an RD_LO phase always intervenes.
- Reset mid-operation: all outputs go immediately to their reset values. After release the block always passes through RST_ADC before IDLE. A partial frame is lost; nothing further is emitted for it.
- Throughput per frame = T_CONV + BUSY time + 2 sync + NCH*(T_RDL+T_RDH) cycles, with ready_i held high.

Decomposition:
- ad7606_pkg: state enum (RST_ADC, IDLE, CONV, WAIT_HI, WAIT_LO, RD_LO, RD_HI), default timing constants, and a CH_W=3 localparam.
- Sub-module ad7606_sync: parameterised-width 2-flop synchronizer with reset_r, instantiated once for {busy, frstdata}.
- The ad7606 behavioural model serves as the bench device-under-drive.

Test Plan:
- Reset release: adc_reset_o high for exactly 4 cycles after reset_r falls. busy_o drops 1 cycle later. All strobes are high.
- Nominal frame: model returns 0x0000..0x0007 on channels 0..7 with ready_i=1. Expect 8 valid beats with chan_o 0..7 and matching data, CS low for the whole read, err flags 0.
- Backpressure: ready_i=0 for 20 cycles on ch3. Expect valid_o held, sample_o=0x0003, adc_rd_o high and adc_cs_o low throughout. The frame then completes with all 8 samples.
- FRSTDATA fault: model asserts FRSTDATA on ch2 instead of ch0. Expect err_frst_o set and sticky; all 8 samples still delivered. The next start_i clears the flag.
- BUSY stuck low: model never raises BUSY. Expect err_to_o one-cycle pulse 1000 cycles after CONV ends, return to IDLE, no valid_o.
- Mid-frame reset: assert reset_r during ch5 RD_LO. Expect strobes high immediately and valid_o=0. After release, the RST_ADC pulse occurs and the next start_i yields a full frame from ch0.

Source files
------------

// File: rtl/ad7606_pkg.sv
// Shared types and default timing for the AD7606 parallel-interface controller.
package ad7606_pkg;

  localparam int unsigned CH_W   = 3;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 16;

  localparam int unsigned NCH_DEF     = 8;
  localparam int unsigned T_RST_DEF   = 4;
  localparam int unsigned T_CONV_DEF  = 3;
  localparam int unsigned T_RDL_DEF   = 3;
  localparam int unsigned T_RDH_DEF   = 2;
  localparam int unsigned BUSY_TO_DEF = 1000;

  typedef enum logic [2:0] {
    RST_ADC,
    IDLE,
    CONV,
    WAIT_HI,
    WAIT_LO,
    RD_LO,
    RD_HI
  } state_e;

  // FRSTDATA is high only while the first channel of a conversion is on the bus.
  function automatic logic frst_expected(input logic [CH_W-1:0] ch);
    return (ch == '0);
  endfunction

endpackage

// File: rtl/ad7606_sync.sv
// Two-flop synchronizer for asynchronous ADC status pins.
module ad7606_sync #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         reset_r,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk or posedge reset_r) begin
    if (reset_r) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/ad7606_ctrl.sv
// AD7606 parallel-interface controller: reset pulse, CONVST, BUSY tracking,
// CS/RD channel reads and a valid/ready sample stream.
module ad7606_ctrl
  import ad7606_pkg::*;
#(
  parameter int unsigned NCH     = NCH_DEF,
  parameter int unsigned T_RST   = T_RST_DEF,
  parameter int unsigned T_CONV  = T_CONV_DEF,
  parameter int unsigned T_RDL   = T_RDL_DEF,
  parameter int unsigned T_RDH   = T_RDH_DEF,
  parameter int unsigned BUSY_TO = BUSY_TO_DEF
) (
  input  logic              clk,
  input  logic              reset_r,
  input  logic              start_i,
  output logic              adc_reset_o,
  output logic              adc_convst_o,
  output logic              adc_cs_o,
  output logic              adc_rd_o,
  input  logic              adc_busy_i,
  input  logic              adc_frstdata_i,
  input  logic [DATA_W-1:0] adc_db_i,
  output logic [DATA_W-1:0] sample_o,
  output logic [CH_W-1:0]   chan_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              busy_o,
  output logic              err_frst_o,
  output logic              err_to_o
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic              acc_q, acc_d;
  logic              acc_now;
  logic              adc_reset_q, adc_reset_d;
  logic              convst_q, convst_d;
  logic              cs_q, cs_d;
  logic              rd_q, rd_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] sample_q, sample_d;
  logic [CH_W-1:0]   chan_q, chan_d;
  logic              busy_q, busy_d;
  logic              err_frst_q, err_frst_d;
  logic              err_to_q, err_to_d;

  logic [1:0]        sync_s;
  logic              busy_s;
  logic              frst_s;

  ad7606_sync #(.W(2)) u_sync (
    .clk     (clk),
    .reset_r (reset_r),
    .d_i     ({adc_busy_i, adc_frstdata_i}),
    .q_o     (sync_s)
  );

  assign busy_s = sync_s[1];
  assign frst_s = sync_s[0];

  // Next-state, counters and next values of every registered output.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ch_d       = ch_q;
    acc_d      = acc_q;
    acc_now    = 1'b0;
    sample_d   = sample_q;
    chan_d     = chan_q;
    valid_d    = valid_q && !ready_i;
    err_frst_d = err_frst_q;
    err_to_d   = 1'b0;

    case (state_q)
      RST_ADC: begin
        if (cnt_q >= CNT_W'(T_RST - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      IDLE: begin
        if (start_i) begin
          state_d    = CONV;
          cnt_d      = '0;
          err_frst_d = 1'b0;
        end
      end
      CONV: begin
        if (cnt_q >= CNT_W'(T_CONV - 1)) begin
          state_d = WAIT_HI;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      // One counter spans both BUSY phases so the window is bounded as a whole.
      WAIT_HI: begin
        if (busy_s) begin
          state_d = WAIT_LO;
          cnt_d   = cnt_q + CNT_W'(1);
        end else if (cnt_q >= CNT_W'(BUSY_TO - 1)) begin
          state_d  = IDLE;
          err_to_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_LO: begin
        if (!busy_s) begin
          state_d = RD_LO;
          cnt_d   = '0;
          ch_d    = '0;
        end else if (cnt_q >= CNT_W'(BUSY_TO - 1)) begin
          state_d  = IDLE;
          err_to_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RD_LO: begin
        if (cnt_q >= CNT_W'(T_RDL - 1)) begin
          state_d  = RD_HI;
          cnt_d    = '0;
          acc_d    = 1'b0;
          sample_d = adc_db_i;
          chan_d   = ch_q;
          valid_d  = 1'b1;
          if (frst_s != frst_expected(ch_q)) begin
            err_frst_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RD_HI: begin
        acc_now = acc_q || (valid_q && ready_i);
        acc_d   = acc_now;
        if (cnt_q < CNT_W'(T_RDH - 1)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (acc_now && (cnt_q >= CNT_W'(T_RDH - 1))) begin
          cnt_d = '0;
          if (ch_q == CH_W'(NCH - 1)) begin
            state_d = IDLE;
          end else begin
            ch_d    = ch_q + CH_W'(1);
            state_d = RD_LO;
          end
        end
      end
      default: begin
        state_d = RST_ADC;
        cnt_d   = '0;
      end
    endcase

    adc_reset_d = (state_d == RST_ADC);
    convst_d    = (state_d != CONV);
    rd_d        = (state_d != RD_LO);
    cs_d        = !((state_d == RD_LO) || (state_d == RD_HI));
    busy_d      = (state_q != IDLE);
  end

  always_ff @(posedge clk or posedge reset_r) begin
    if (reset_r) begin
      state_q     <= RST_ADC;
      cnt_q       <= '0;
      ch_q        <= '0;
      acc_q       <= 1'b0;
      adc_reset_q <= 1'b1;
      convst_q    <= 1'b1;
      cs_q        <= 1'b1;
      rd_q        <= 1'b1;
      valid_q     <= 1'b0;
      sample_q    <= '0;
      chan_q      <= '0;
      busy_q      <= 1'b1;
      err_frst_q  <= 1'b0;
      err_to_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ch_q        <= ch_d;
      acc_q       <= acc_d;
      adc_reset_q <= adc_reset_d;
      convst_q    <= convst_d;
      cs_q        <= cs_d;
      rd_q        <= rd_d;
      valid_q     <= valid_d;
      sample_q    <= sample_d;
      chan_q      <= chan_d;
      busy_q      <= busy_d;
      err_frst_q  <= err_frst_d;
      err_to_q    <= err_to_d;
    end
  end

  assign adc_reset_o  = adc_reset_q;
  assign adc_convst_o = convst_q;
  assign adc_cs_o     = cs_q;
  assign adc_rd_o     = rd_q;
  assign valid_o      = valid_q;
  assign sample_o     = sample_q;
  assign chan_o       = chan_q;
  assign busy_o       = busy_q;
  assign err_frst_o   = err_frst_q;
  assign err_to_o     = err_to_q;

endmodule
